reg_file_bypass: RTL and testbench
==================================

REG_FILE_BYPASS -- requirements
Module: reg_file_bypass

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, giving the register index width; the block holds 2**ADDR_W registers.
REQ-003 The block SHALL have parameter NRD, default 2, giving the number of read ports.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 rd_addr  in  NRD*ADDR_W  read indices; port k uses bits [k*ADDR_W +: ADDR_W].
REQ-007 rd_data  out  NRD*DATA_W  read data, packed the same way as rd_addr.
REQ-008 rd_busy  out  NRD  per read port: the addressed register has a pending writer.
REQ-009 wa_en / wa_addr / wa_data  in  1 / ADDR_W / DATA_W  write port A (low priority).
REQ-010 wb_en / wb_addr / wb_data  in  1 / ADDR_W / DATA_W  write port B (high priority).
REQ-011 iss_en / iss_addr  in  1 / ADDR_W  issue: mark a register as having a pending writer.
REQ-012 pend_cnt  out  ADDR_W+1  registered count of set pending bits.

Function
REQ-013 Register 0 SHALL read as zero at all times; writes to it are discarded; its pending bit never sets.
REQ-014 Reads SHALL be combinational: rd_data[k] = the register contents at rd_addr[k], with bypass applied per REQ-015.
REQ-015 Bypass: if wb_en and wb_addr == rd_addr[k] != 0, rd_data[k] = wb_data; otherwise, if wa_en and wa_addr == rd_addr[k] != 0, rd_data[k] = wa_data.
REQ-016 On a clock edge, each enabled write port with a non-zero address SHALL update its register.
REQ-017 If both ports are enabled with the same address, port B's data SHALL be stored.
REQ-018 A write through either port to address r SHALL clear pending[r] at the same edge.
REQ-019 iss_en with iss_addr != 0 SHALL set pending[iss_addr] at the edge.
REQ-020 If an issue and a write target the same register in one cycle, the issue SHALL win: pending stays 1 and the data is written.
REQ-021 rd_busy[k] SHALL be combinational: pending[rd_addr[k]] AND NOT (a same-cycle write to rd_addr[k] per REQ-015). The bypassed value is therefore reported as not busy.
REQ-022 Issuing to an already-pending register SHALL leave the bit set; there is no counting per register.
REQ-023 Writing a register that is not pending SHALL be legal and SHALL leave pending unchanged (0).
REQ-024 pend_cnt SHALL equal the popcount of the pending vector after each edge, i.e. one cycle of latency from the event; its range is 0..2**ADDR_W-1.

Reset
REQ-025 While reset = 0, asynchronously and regardless of clk: all registers = 0, all pending bits = 0, pend_cnt = 0.
REQ-026 Writes or issues coinciding with reset assertion SHALL be lost.
REQ-027 The first edge after reset rises SHALL behave normally.

Structure
REQ-028 A shared package SHALL hold the default DATA_W/ADDR_W/NRD and the ZERO_REG index constant.
REQ-029 The pending vector and pend_cnt SHALL live in one sub-module, rf_scoreboard; the data array and bypass logic SHALL be in the top level.

Verification
REQ-030 Reset with registers preloaded, then release -> all rd_data = 0, rd_busy = 0, pend_cnt = 0.
REQ-031 wa writes 0xDEADBEEF to r3 while rd_addr[0] = 3 -> rd_data[0] = 0xDEADBEEF in the same cycle; r3 still holds it the next cycle.
REQ-032 wa and wb both write r5 (0x11111111 and 0x22222222) -> same-cycle read = 0x22222222; stored value = 0x22222222.
REQ-033 Issue r7 -> rd_busy = 1 and pend_cnt = 1 one cycle later; wb writes r7 = 0x7 -> busy drops in that cycle (bypass); pend_cnt = 0 after the edge.
REQ-034 In one cycle: issue r9 plus wa write r9 = 0x9 -> r9 = 0x9, pending[9] = 1; issue r0 or write r0 = 0xFF -> r0 reads 0, pend_cnt unchanged.
REQ-035 Issue all 31 non-zero registers, then assert reset mid-sequence -> pend_cnt = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/reg_file_bypass_pkg.sv
// Shared defaults for the bypassing register file and its pending-writer scoreboard.
package reg_file_bypass_pkg;

   localparam int unsigned RF_DATA_W = 32;
   localparam int unsigned RF_ADDR_W = 5;
   localparam int unsigned RF_NRD    = 2;

   // Hard-wired zero register: never stored, never pending, never bypassed.
   localparam int unsigned ZERO_REG  = 0;

endpackage

// File: rtl/reg_file_bypass_rf_scoreboard.sv
// Pending-writer bits, one per register, plus a registered popcount of the set bits.
module rf_scoreboard
   import reg_file_bypass_pkg::*;
#(
   parameter int unsigned ADDR_W = RF_ADDR_W
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      wa_en,
   input  logic [ADDR_W-1:0]         wa_addr,
   input  logic                      wb_en,
   input  logic [ADDR_W-1:0]         wb_addr,
   input  logic                      iss_en,
   input  logic [ADDR_W-1:0]         iss_addr,
   output logic [(2**ADDR_W)-1:0]    pend_vec,
   output logic [ADDR_W:0]           pend_cnt
);

   localparam int unsigned NREG = 2**ADDR_W;

   logic [NREG-1:0] pend_q, pend_d;
   logic [ADDR_W:0] cnt_q, cnt_d;

   always_comb begin
      pend_d = pend_q;
      if (wa_en) pend_d[wa_addr] = 1'b0;
      if (wb_en) pend_d[wb_addr] = 1'b0;
      // Applied after the clears so a same-cycle issue keeps the bit set.
      if (iss_en) pend_d[iss_addr] = 1'b1;
      pend_d[ZERO_REG] = 1'b0;

      cnt_d = '0;
      for (int i = 0; i < int'(NREG); i++) begin
         cnt_d = cnt_d + (ADDR_W+1)'(pend_d[i]);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_q <= '0;
         cnt_q  <= '0;
      end else begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end

   assign pend_vec = pend_q;
   assign pend_cnt = cnt_q;

endmodule

// File: rtl/reg_file_bypass.sv
// Two-write-port register file with combinational read bypass and per-register busy flags.
module reg_file_bypass
   import reg_file_bypass_pkg::*;
#(
   parameter int unsigned DATA_W = RF_DATA_W,
   parameter int unsigned ADDR_W = RF_ADDR_W,
   parameter int unsigned NRD    = RF_NRD
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NRD*ADDR_W-1:0]   rd_addr,
   output logic [NRD*DATA_W-1:0]   rd_data,
   output logic [NRD-1:0]          rd_busy,
   input  logic                    wa_en,
   input  logic [ADDR_W-1:0]       wa_addr,
   input  logic [DATA_W-1:0]       wa_data,
   input  logic                    wb_en,
   input  logic [ADDR_W-1:0]       wb_addr,
   input  logic [DATA_W-1:0]       wb_data,
   input  logic                    iss_en,
   input  logic [ADDR_W-1:0]       iss_addr,
   output logic [ADDR_W:0]         pend_cnt
);

   localparam int unsigned NREG = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

   logic [DATA_W-1:0] mem_q [NREG];
   logic [NREG-1:0]   pend_vec;

   logic wa_live, wb_live, iss_live;

   assign wa_live  = wa_en  && (wa_addr  != ZERO_ADDR);
   assign wb_live  = wb_en  && (wb_addr  != ZERO_ADDR);
   assign iss_live = iss_en && (iss_addr != ZERO_ADDR);

   rf_scoreboard #(
      .ADDR_W   (ADDR_W)
   ) u_scoreboard (
      .clk      (clk),
      .reset    (reset),
      .wa_en    (wa_live),
      .wa_addr  (wa_addr),
      .wb_en    (wb_live),
      .wb_addr  (wb_addr),
      .iss_en   (iss_live),
      .iss_addr (iss_addr),
      .pend_vec (pend_vec),
      .pend_cnt (pend_cnt)
   );

   // Port B is written last so it owns a same-address collision.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(NREG); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (wa_live) mem_q[wa_addr] <= wa_data;
         if (wb_live) mem_q[wb_addr] <= wb_data;
      end
   end

   logic [ADDR_W-1:0] ra;
   logic              ra_live, hit_a, hit_b;

   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      ra      = '0;
      ra_live = 1'b0;
      hit_a   = 1'b0;
      hit_b   = 1'b0;
      for (int k = 0; k < int'(NRD); k++) begin
         ra      = rd_addr[k*ADDR_W +: ADDR_W];
         ra_live = (ra != ZERO_ADDR);
         hit_b   = wb_live && (wb_addr == ra);
         hit_a   = wa_live && (wa_addr == ra);
         if (!ra_live)   rd_data[k*DATA_W +: DATA_W] = '0;
         else if (hit_b) rd_data[k*DATA_W +: DATA_W] = wb_data;
         else if (hit_a) rd_data[k*DATA_W +: DATA_W] = wa_data;
         else            rd_data[k*DATA_W +: DATA_W] = mem_q[ra];
         // A register being written this cycle is served by the bypass, so it is not busy.
         rd_busy[k] = ra_live && pend_vec[ra] && !(hit_a || hit_b);
      end
   end

endmodule

// File: tb/tb_reg_file_bypass.sv
// Directed and randomized checks of reg_file_bypass against an array-based reference model.
module tb_reg_file_bypass;

   localparam int DW   = 32;
   localparam int AW   = 5;
   localparam int NRD  = 2;
   localparam int NREG = 1 << AW;

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic [NRD*AW-1:0]  rd_addr = '0;
   logic [NRD*DW-1:0]  rd_data;
   logic [NRD-1:0]     rd_busy;
   logic               wa_en = 1'b0, wb_en = 1'b0, iss_en = 1'b0;
   logic [AW-1:0]      wa_addr = '0, wb_addr = '0, iss_addr = '0;
   logic [DW-1:0]      wa_data = '0, wb_data = '0;
   logic [AW:0]        pend_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   logic [DW-1:0] m_mem  [NREG];
   bit            m_pend [NREG];

   reg_file_bypass #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD)) dut (
      .clk      (clk),
      .reset    (reset),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_busy  (rd_busy),
      .wa_en    (wa_en),
      .wa_addr  (wa_addr),
      .wa_data  (wa_data),
      .wb_en    (wb_en),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .pend_cnt (pend_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int model_popcount();
      int c = 0;
      for (int i = 0; i < NREG; i++) c += int'(m_pend[i]);
      return c;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NREG; i++) begin
         m_mem[i]  = '0;
         m_pend[i] = 1'b0;
      end
   endtask

   task automatic idle();
      wa_en = 1'b0; wb_en = 1'b0; iss_en = 1'b0;
   endtask

   task automatic set_rd(input int a0, input int a1);
      rd_addr[0 +: AW]  = AW'(a0);
      rd_addr[AW +: AW] = AW'(a1);
   endtask

   // Checks every read port and the pending count against the model.
   task automatic check_comb(input string tag);
      int ra;
      logic [DW-1:0] e_data;
      bit e_busy, wr_hit;
      #1;
      for (int k = 0; k < NRD; k++) begin
         ra = int'(rd_addr[k*AW +: AW]);
         wr_hit = 1'b0;
         if (ra == 0) e_data = '0;
         else if (wb_en && int'(wb_addr) == ra) begin e_data = wb_data; wr_hit = 1'b1; end
         else if (wa_en && int'(wa_addr) == ra) begin e_data = wa_data; wr_hit = 1'b1; end
         else e_data = m_mem[ra];
         e_busy = (ra != 0) && m_pend[ra] && !wr_hit;
         chk($sformatf("%s rd_data[%0d]", tag, k), 64'(rd_data[k*DW +: DW]), 64'(e_data));
         chk($sformatf("%s rd_busy[%0d]", tag, k), 64'(rd_busy[k]), 64'(e_busy));
      end
      chk($sformatf("%s pend_cnt", tag), 64'(pend_cnt), 64'(model_popcount()));
   endtask

   task automatic tick();
      @(posedge clk);
      if (!reset) model_clear();
      else begin
         if (wa_en && wa_addr != 0) begin m_mem[wa_addr] = wa_data; m_pend[wa_addr] = 1'b0; end
         if (wb_en && wb_addr != 0) begin m_mem[wb_addr] = wb_data; m_pend[wb_addr] = 1'b0; end
         if (iss_en && iss_addr != 0) m_pend[iss_addr] = 1'b1;
      end
      @(negedge clk);
   endtask

   initial begin
      model_clear();
      idle();
      @(negedge clk);
      reset = 1'b1;

      // Preload registers and pending bits, then reset mid-cycle.
      for (int i = 1; i <= 6; i++) begin
         wa_en = 1'b1; wa_addr = AW'(i); wa_data = DW'(32'h1000 + i);
         iss_en = 1'b1; iss_addr = AW'(i + 10);
         tick();
      end
      idle();
      set_rd(1, 11);
      check_comb("preload");
      #2 reset = 1'b0;
      model_clear();
      check_comb("async_reset");
      chk("async_reset cnt_zero", 64'(pend_cnt), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      set_rd(2, 12);
      check_comb("post_reset");

      // Bypass from port A, then stored value visible.
      wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'hDEADBEEF;
      set_rd(3, 4);
      check_comb("wa_bypass");
      chk("wa_bypass const", 64'(rd_data[0 +: DW]), 64'h0DEADBEEF);
      tick();
      idle();
      check_comb("wa_stored");
      chk("wa_stored const", 64'(rd_data[0 +: DW]), 64'h0DEADBEEF);

      // Both ports target r5; port B wins in bypass and storage.
      wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'h11111111;
      wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h22222222;
      set_rd(3, 5);
      check_comb("ab_bypass");
      chk("ab_bypass const", 64'(rd_data[DW +: DW]), 64'h22222222);
      tick();
      idle();
      check_comb("ab_stored");
      chk("ab_stored const", 64'(rd_data[DW +: DW]), 64'h22222222);

      // Issue r7, then write it through port B.
      iss_en = 1'b1; iss_addr = 5'd7;
      tick();
      idle();
      set_rd(7, 0);
      check_comb("iss7");
      chk("iss7 busy", 64'(rd_busy[0]), 64'd1);
      chk("iss7 cnt", 64'(pend_cnt), 64'd1);
      wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h7;
      check_comb("wb7_bypass");
      chk("wb7 busy_drop", 64'(rd_busy[0]), 64'd0);
      tick();
      idle();
      check_comb("wb7_done");
      chk("wb7 cnt", 64'(pend_cnt), 64'd0);

      // Issue and write on r9 together; then zero-register traffic.
      iss_en = 1'b1; iss_addr = 5'd9;
      wa_en = 1'b1; wa_addr = 5'd9; wa_data = 32'h9;
      tick();
      idle();
      set_rd(9, 9);
      check_comb("iw9");
      chk("iw9 data", 64'(rd_data[0 +: DW]), 64'h9);
      chk("iw9 busy", 64'(rd_busy[0]), 64'd1);
      iss_en = 1'b1; iss_addr = 5'd0;
      wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hFF;
      set_rd(0, 9);
      check_comb("r0_bypass");
      chk("r0 read_zero", 64'(rd_data[0 +: DW]), 64'd0);
      tick();
      idle();
      check_comb("r0_after");
      chk("r0 cnt_unchanged", 64'(pend_cnt), 64'd1);

      // Randomized traffic, biased to a few addresses for frequent collisions.
      for (int n = 0; n < 400; n++) begin
         wa_en    = 1'($urandom_range(0, 1));
         wb_en    = 1'($urandom_range(0, 1));
         iss_en   = 1'($urandom_range(0, 1));
         wa_addr  = AW'($urandom_range(0, 7));
         wb_addr  = AW'($urandom_range(0, 7));
         iss_addr = AW'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) wa_addr = AW'($urandom);
         wa_data  = DW'($urandom);
         wb_data  = DW'($urandom);
         set_rd(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
         check_comb("rand");
         tick();
      end
      idle();

      // Fill every pending bit, then reset asynchronously.
      for (int i = 1; i < NREG; i++) begin
         iss_en = 1'b1; iss_addr = AW'(i);
         tick();
      end
      idle();
      set_rd(31, 17);
      check_comb("all_pend");
      chk("all_pend cnt", 64'(pend_cnt), 64'd31);
      #2 reset = 1'b0;
      model_clear();
      check_comb("all_pend_reset");
      chk("all_pend_reset cnt", 64'(pend_cnt), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'hA5A5A5A5;
      iss_en = 1'b1; iss_addr = 5'd6;
      tick();
      idle();
      set_rd(4, 6);
      check_comb("first_edge");
      chk("first_edge data", 64'(rd_data[0 +: DW]), 64'hA5A5A5A5);
      chk("first_edge cnt", 64'(pend_cnt), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
